mult_share_ctrl: RTL and testbench
==================================

Name: mult_share_ctrl

Overview:
- Round-robin scheduler that shares one three-cycle 8x8 multiplier (start/done_mult handshake, 16-bit result) among N_REQ requesters.
- Arbitrates, issues one operation at a time, drives the multiplier's A/B/start, captures the result on done and routes it back with the requester ID.
- Adds a watchdog timeout and a post-timeout pipeline drain.
- Sits between requesting blocks and the multiplier instance at the ALU top level.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), requester ID width (derived; do not override).
- TIMEOUT, 16, cycles in ISSUE without mult_done before an error response (>=6).
- DRAIN, 4, cycles mult_start is held low after a timeout before re-arbitration.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset; the multiplier's reset_n is driven from !reset at top level.
- req  in  N_REQ  per-requester request level; held high until that requester's ack.
- req_a  in  8*N_REQ  packed operand A; slice i = req_a[8i+7:8i].
- req_b  in  8*N_REQ  packed operand B, same packing.
- ack  out  N_REQ  one-hot, one-cycle pulse: request accepted and operands captured.
- resp_valid  out  1  one-cycle pulse: result available.
- resp_id  out  ID_W  requester index for the response.
- resp_result  out  16  product, or 0 on error.
- resp_err  out  1  timeout flag, valid with resp_valid.
- busy  out  1  high whenever state != IDLE.
- mult_a, mult_b  out  8 each  multiplier operands, held stable for the whole operation.
- mult_start  out  1  multiplier start.
- mult_done  in  1  multiplier done_mult.
- mult_result  in  16  multiplier result_mult.

Behaviour:
- All outputs are registered. On reset: all outputs 0, state IDLE, rr_ptr = N_REQ-1, timer 0. This applies equally mid-operation: in-flight work is abandoned without a response, and unacked requests are re-arbitrated after reset.
- **State IDLE.** If any req is high, grant the first requester searching from rr_ptr+1 mod N_REQ upward with wrap-around.
  - Register mult_a/mult_b from the granted slices, set mult_start=1, pulse ack[g], store g, set rr_ptr=g, go to ISSUE.
  - Requests arriving in the same cycle are resolved purely by the round-robin order.
- **State ISSUE.** Hold mult_start=1 and mult_a/mult_b constant; timer increments each cycle.
  - mult_done=1: capture mult_result, clear mult_start, then go to RESP.
  - timer reaches TIMEOUT-1 without done: clear mult_start, set resp_err, set resp_result 0, then go to RESP.
  - Done wins if both occur in the same cycle.
- **State RESP.** One cycle with resp_valid=1, resp_id=stored g, resp_result/resp_err valid.
  - Normal completion goes to IDLE.
  - After a timeout, go to DRAIN.
- **State DRAIN.** Hold mult_start=0 for DRAIN cycles, then go to IDLE.
- mult_done is ignored outside ISSUE.
- Timing for a request sampled in IDLE cycle t with a healthy multiplier:
  - ack[g] and mult_start rise in cycle t+1.
  - mult_done is high in cycle t+5.
  - resp_valid is in cycle t+6, with mult_start low from t+6.
  - IDLE is in cycle t+7; the earliest next mult_start is t+8.
  - Result: mult_start always has at least 2 low cycles between operations, which guarantees the multiplier's done gating clears.
  - Throughput: one operation per 7 cycles.
- resp_result = unsigned 8x8 product, full 16 bits, no truncation.
- A requester may raise a new req in the cycle after its ack; it is not eligible again until rr_ptr passes it.

Test Plan:
- **Single request:** reset 2 cycles; req[2]=1, a=0x0C, b=0x0D in cycle t -> ack[2] at t+1; mult_a=0x0C, mult_b=0x0D; resp_valid at t+6 with resp_id=2, resp_result=0x009C, resp_err=0.
- **Max operands:** req[0] with a=b=0xFF -> resp_result=0xFE01. Then a=0x00, b=0xAB -> 0x0000. No extra resp_valid pulses.
- **Fairness:** all four req held high continuously -> ack order 0,1,2,3,0,… with acks 7 cycles apart. Each resp_id matches the preceding ack. mult_start is low for at least 2 cycles between operations.
- **Timeout:** replace the multiplier with a model that never asserts done; req[1] -> resp_valid after 16 ISSUE cycles with resp_err=1, resp_result=0, resp_id=1. Then mult_start is low for 4 DRAIN cycles, busy=1 throughout, then IDLE.
- **Reset mid-operation:** assert reset for 1 cycle in the third ISSUE cycle -> all outputs 0 the next cycle, no resp_valid for that operation. A still-high req[3] is re-acked with rr_ptr restarted, so req[0] wins if it is also pending.
- **Done/timeout collision:** multiplier model asserts done exactly at timer=TIMEOUT-1 -> resp_err=0, resp_result=the captured product, no DRAIN.

Source files
------------

// File: rtl/mult_share_if.sv
// Bundle between the shared-multiplier scheduler, its requesters and the multiplier.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface mult_share_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_a;
    logic [8*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   ack;
    logic               resp_valid;
    logic [ID_W-1:0]    resp_id;
    logic [15:0]        resp_result;
    logic               resp_err;
    logic               busy;
    logic [7:0]         mult_a;
    logic [7:0]         mult_b;
    logic               mult_start;
    logic               mult_done;
    logic [15:0]        mult_result;

    modport slave (
        input  req, req_a, req_b, mult_done, mult_result,
        output ack, resp_valid, resp_id, resp_result, resp_err, busy,
               mult_a, mult_b, mult_start
    );

    modport master (
        output req, req_a, req_b, mult_done, mult_result,
        input  ack, resp_valid, resp_id, resp_result, resp_err, busy,
               mult_a, mult_b, mult_start
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one 8x8 multiplier among N_REQ requesters,
// with a watchdog timeout and a drain period before re-arbitrating.
module mult_share_ctrl #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16,
    parameter int DRAIN   = 4
) (
    input  logic        clk,
    input  logic        reset,
    mult_share_if.slave bus
);
    localparam int ID_W    = $clog2(N_REQ);
    localparam int TMR_MAX = (TIMEOUT > DRAIN) ? TIMEOUT : DRAIN;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_DRAIN} state_t;

    state_t             r_state, w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr, w_rr_ptr;
    logic [ID_W-1:0]    r_gnt_id, w_gnt_id;
    logic [TMR_W-1:0]   r_timer, w_timer;
    logic [N_REQ-1:0]   r_ack, w_ack;
    logic               r_resp_valid, w_resp_valid;
    logic [ID_W-1:0]    r_resp_id, w_resp_id;
    logic [15:0]        r_resp_result, w_resp_result;
    logic               r_resp_err, w_resp_err;
    logic               r_busy, w_busy;
    logic [7:0]         r_mult_a, w_mult_a;
    logic [7:0]         r_mult_b, w_mult_b;
    logic               r_mult_start, w_mult_start;

    logic               w_found;
    logic [ID_W-1:0]    w_gnt;
    logic [ID_W-1:0]    w_idx;

    // Search starts just past the last winner, so the last winner has lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr      = r_rr_ptr;
        w_gnt_id      = r_gnt_id;
        w_timer       = r_timer;
        w_ack         = '0;
        w_resp_valid  = 1'b0;
        w_resp_id     = r_resp_id;
        w_resp_result = r_resp_result;
        w_resp_err    = r_resp_err;
        w_mult_a      = r_mult_a;
        w_mult_b      = r_mult_b;
        w_mult_start  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_mult_a     = 8'(bus.req_a >> {w_gnt, 3'b000});
                    w_mult_b     = 8'(bus.req_b >> {w_gnt, 3'b000});
                    w_mult_start = 1'b1;
                    w_ack        = N_REQ'(1) << w_gnt;
                    w_gnt_id     = w_gnt;
                    w_rr_ptr     = w_gnt;
                    w_timer      = '0;
                    w_state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A done arriving on the last watchdog cycle still counts as success.
                if (bus.mult_done) begin
                    w_resp_valid  = 1'b1;
                    w_resp_id     = r_gnt_id;
                    w_resp_result = bus.mult_result;
                    w_resp_err    = 1'b0;
                    w_state_nxt   = S_RESP;
                end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                    w_resp_valid  = 1'b1;
                    w_resp_id     = r_gnt_id;
                    w_resp_result = '0;
                    w_resp_err    = 1'b1;
                    w_state_nxt   = S_RESP;
                end else begin
                    w_timer      = r_timer + TMR_W'(1);
                    w_mult_start = 1'b1;
                end
            end
            S_RESP: begin
                if (r_resp_err) begin
                    w_timer     = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (r_timer == TMR_W'(DRAIN - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer = r_timer + TMR_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_busy = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= ID_W'(N_REQ - 1);
            r_gnt_id      <= '0;
            r_timer       <= '0;
            r_ack         <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
            r_busy        <= 1'b0;
            r_mult_a      <= '0;
            r_mult_b      <= '0;
            r_mult_start  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr;
            r_gnt_id      <= w_gnt_id;
            r_timer       <= w_timer;
            r_ack         <= w_ack;
            r_resp_valid  <= w_resp_valid;
            r_resp_id     <= w_resp_id;
            r_resp_result <= w_resp_result;
            r_resp_err    <= w_resp_err;
            r_busy        <= w_busy;
            r_mult_a      <= w_mult_a;
            r_mult_b      <= w_mult_b;
            r_mult_start  <= w_mult_start;
        end
    end

    assign bus.ack         = r_ack;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_id     = r_resp_id;
    assign bus.resp_result = r_resp_result;
    assign bus.resp_err    = r_resp_err;
    assign bus.busy        = r_busy;
    assign bus.mult_a      = r_mult_a;
    assign bus.mult_b      = r_mult_b;
    assign bus.mult_start  = r_mult_start;
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: job-queue requesters, a latency-programmable multiplier,
// a transaction-level predictor feeding expectation queues, and a separate monitor.
module tb_mult_share_ctrl;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int DR = 4;
    localparam int AW = 8 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_share_if #(.N_REQ(N)) bus ();

    mult_share_ctrl #(.N_REQ(N), .TIMEOUT(TO), .DRAIN(DR)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Multiplier model: done after mult_lat cycles of continuous start; huge latency = never.
    int mult_lat = 4;
    int m_cnt;
    always @(posedge clk) begin
        if (rst || !bus.mult_start) m_cnt <= 0;
        else                        m_cnt <= m_cnt + 1;
    end
    assign bus.mult_done   = bus.mult_start && (m_cnt == mult_lat);
    assign bus.mult_result = 16'(bus.mult_a) * 16'(bus.mult_b);

    typedef struct packed { int cyc; int id; logic [7:0] a; logic [7:0] b; } ack_t;
    typedef struct packed { int cyc; int id; logic [15:0] res; logic err; } resp_t;
    typedef struct packed { logic [7:0] a; logic [7:0] b; } job_t;

    ack_t  ack_q[$];
    resp_t resp_q[$];
    job_t  jobs[N][$];

    int cyc = 0, rr = N - 1, free_at = 0, busy_from = 0, start_end = 0, rst_chk = -1;
    bit mon_en = 1'b0;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic [7:0] a, input logic [7:0] b);
        job_t j;
        j.a = a;
        j.b = b;
        jobs[i].push_back(j);
    endtask

    // Requesters: hold req with the head job's operands until acked.
    initial begin : driver
        logic [N-1:0] ackd, rv;
        logic [AW-1:0] va, vb;
        bus.req = '0; bus.req_a = '0; bus.req_b = '0;
        forever begin
            @(negedge clk);
            ackd = bus.ack;
            @(posedge clk);
            #1;
            rv = '0; va = '0; vb = '0;
            for (int i = 0; i < N; i++) begin
                if (((ackd >> i) & N'(1)) == N'(1) && jobs[i].size() > 0)
                    void'(jobs[i].pop_front());
                if (jobs[i].size() > 0) begin
                    rv = rv | (N'(1) << i);
                    va = va | (AW'(jobs[i][0].a) << (8 * i));
                    vb = vb | (AW'(jobs[i][0].b) << (8 * i));
                end
            end
            bus.req = rv; bus.req_a = va; bus.req_b = vb;
        end
    end

    // Predictor: one operation at a time; winner is first pending index after the last winner.
    initial begin : predictor
        int c, g, idx, lat, rc;
        logic [N-1:0] rv;
        ack_t ea;
        resp_t er;
        forever begin
            @(posedge clk);
            c = cyc;
            cyc = cyc + 1;
            rv = bus.req;
            if (rst) begin
                ack_q.delete();
                resp_q.delete();
                rr = N - 1;
                free_at = c + 1; busy_from = c + 1; start_end = c + 1; rst_chk = c + 1;
            end else if (c >= free_at && rv != '0) begin
                g = -1;
                for (int k = 1; k <= N; k++) begin
                    idx = (rr + k) % N;
                    if (g < 0 && ((rv >> idx) & N'(1)) == N'(1)) g = idx;
                end
                ea.cyc = c + 1; ea.id = g;
                ea.a = 8'(bus.req_a >> (8 * g));
                ea.b = 8'(bus.req_b >> (8 * g));
                ack_q.push_back(ea);
                lat = mult_lat;
                er.id = g;
                if (lat <= TO - 1) begin
                    rc = c + 2 + lat;
                    er.res = 16'(ea.a) * 16'(ea.b);
                    er.err = 1'b0;
                    free_at = rc + 1;
                end else begin
                    rc = c + 1 + TO;
                    er.res = 16'h0;
                    er.err = 1'b1;
                    free_at = rc + 1 + DR;
                end
                er.cyc = rc;
                resp_q.push_back(er);
                rr = g;
                busy_from = c + 1;
                start_end = rc;
            end
        end
    end

    // Monitor: compares DUT outputs against the expectation queues each cycle.
    initial begin : monitor
        logic [N-1:0] ev;
        bit prev_start;
        int low_run, d;
        ack_t ea;
        resp_t er;
        logic [7:0] cur_a, cur_b;
        prev_start = 1'b0; low_run = 99; cur_a = '0; cur_b = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                d = cyc;
                if (d == rst_chk)
                    chk("reset_outputs", 64'({bus.ack, bus.resp_valid, bus.resp_id, bus.resp_result,
                        bus.resp_err, bus.busy, bus.mult_a, bus.mult_b, bus.mult_start}), 64'h0);
                chk("busy", 64'(bus.busy), 64'(d >= busy_from && d < free_at));
                chk("mult_start", 64'(bus.mult_start), 64'(d >= busy_from && d < start_end));
                if (bus.mult_start) begin
                    if (!prev_start) begin
                        checks++;
                        if (low_run < 2) begin
                            errors++;
                            $display("FAIL start_gap: got %0d low cycles, expected at least 2", low_run);
                        end
                    end
                    low_run = 0;
                end else begin
                    low_run++;
                end
                prev_start = bus.mult_start;
                if (rst) low_run = 99;

                while (ack_q.size() > 0 && ack_q[0].cyc < d) begin
                    ea = ack_q.pop_front();
                    checks++; errors++;
                    $display("FAIL ack_missing: got no ack, expected ack for id %0d in cycle %0d", ea.id, ea.cyc);
                end
                if (bus.ack != '0) begin
                    if (ack_q.size() > 0 && ack_q[0].cyc == d) begin
                        ea = ack_q.pop_front();
                        ev = N'(1) << ea.id;
                        chk("ack_ops", 64'({bus.ack, bus.mult_a, bus.mult_b}), 64'({ev, ea.a, ea.b}));
                        cur_a = ea.a; cur_b = ea.b;
                    end else begin
                        checks++; errors++;
                        $display("FAIL unexpected_ack: got %b expected none in cycle %0d", bus.ack, d);
                    end
                end
                if (bus.mult_start)
                    chk("operands_hold", 64'({bus.mult_a, bus.mult_b}), 64'({cur_a, cur_b}));

                while (resp_q.size() > 0 && resp_q[0].cyc < d) begin
                    er = resp_q.pop_front();
                    checks++; errors++;
                    $display("FAIL resp_missing: got no resp, expected id %0d in cycle %0d", er.id, er.cyc);
                end
                if (bus.resp_valid) begin
                    if (resp_q.size() > 0 && resp_q[0].cyc == d) begin
                        er = resp_q.pop_front();
                        chk("resp", 64'({bus.resp_id, bus.resp_result, bus.resp_err}),
                            64'({2'(er.id), er.res, er.err}));
                    end else begin
                        checks++; errors++;
                        $display("FAIL unexpected_resp: got id %0d result %h, expected none in cycle %0d",
                                 bus.resp_id, bus.resp_result, d);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        bit pend;
        n = 0;
        pend = 1'b1;
        while (pend) begin
            @(negedge clk);
            pend = (ack_q.size() > 0) || (resp_q.size() > 0) || (bus.busy == 1'b1);
            for (int i = 0; i < N; i++) if (jobs[i].size() > 0) pend = 1'b1;
            n++;
            if (pend && n > 3000) begin
                checks++; errors++;
                $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
                pend = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // single request and operand extremes
        push(2, 8'h0C, 8'h0D);
        wait_idle();
        push(0, 8'hFF, 8'hFF);
        push(0, 8'h00, 8'hAB);
        wait_idle();

        // all requesters continuously pending
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++)
                push(i, 8'($urandom), 8'($urandom));
        wait_idle();

        // multiplier that never answers
        mult_lat = 1000;
        push(1, 8'h12, 8'h34);
        wait_idle();
        mult_lat = 4;

        // reset during the third ISSUE cycle of requester 3
        push(3, 8'h11, 8'h22);
        push(3, 8'h33, 8'h44);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ack[3] !== 1'b1 && n < 100);
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL ack3_wait: got no ack[3] in %0d cycles, expected one", n);
        end
        push(0, 8'h55, 8'h66);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle();

        // done on the last watchdog cycle
        mult_lat = TO - 1;
        push(2, 8'hC3, 8'h5A);
        wait_idle();

        // randomized batches, the last one with a silent multiplier
        for (int b = 0; b < 4; b++) begin
            mult_lat = (b == 3) ? TO : $urandom_range(2, 14);
            for (int j = 0; j < 8; j++) begin
                push($urandom_range(0, N - 1), 8'($urandom), 8'($urandom));
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1;
            end
            wait_idle();
        end
        mult_lat = 4;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
